matrix_mult_seq: RTL



---
 rtl/matrix_mult_seq_pkg.sv | 24 ++
 rtl/matrix_mult_seq_mac16.sv | 23 ++
 rtl/matrix_mult_seq.sv | 166 ++++++++++++++++
 3 files changed

// File: rtl/matrix_mult_seq_pkg.sv
// Shared types and constants for the sequenced 4x4 matrix multiplier.
package matrix_pkg;

    localparam int unsigned ELEM_W = 16;
    localparam int unsigned DIM    = 4;
    localparam int unsigned MAT_W  = ELEM_W * DIM * DIM;

    typedef enum logic [1:0] {
        IDLE,
        CALC,
        DONE
    } state_t;

    // Bit offset of element (r,c) in a packed row-major matrix.
    function automatic int unsigned elem_off(
        input int unsigned r,
        input int unsigned c,
        input int unsigned w = ELEM_W,
        input int unsigned d = DIM
    );
        return (r * d + c) * w;
    endfunction

endpackage

// File: rtl/matrix_mult_seq_mac16.sv
// Combinational multiply-accumulate: acc_out = acc_in + low W bits of a*b.
// The low half of a product is the same for signed and unsigned operands,
// so no signedness is attached to the inputs.
module mac16
    import matrix_pkg::*;
#(
    parameter int unsigned W = ELEM_W
) (
    input  logic [W-1:0] a,
    input  logic [W-1:0] b,
    input  logic [W-1:0] acc_in,
    output logic [W-1:0] acc_out
);

    logic [W-1:0] prod_lo;

    // Truncated product plus wrapping accumulate.
    always_comb begin
        prod_lo = a * b;
        acc_out = acc_in + prod_lo;
    end

endmodule

// File: rtl/matrix_mult_seq.sv
// Sequenced DIMxDIM matrix multiplier: one MAC step per cycle, row-major
// result order, packed product published with a one-cycle done pulse.
module matrix_mult_seq
    import matrix_pkg::*;
#(
    parameter int unsigned ELEM_W = 16,
    parameter int unsigned DIM    = 4
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       start,
    input  logic [ELEM_W*DIM*DIM-1:0]  m1,
    input  logic [ELEM_W*DIM*DIM-1:0]  m2,
    output logic                       busy,
    output logic                       done,
    output logic [ELEM_W*DIM*DIM-1:0]  m_out
);

    localparam int unsigned MW    = ELEM_W * DIM * DIM;
    localparam int unsigned CNT_W = (DIM > 1) ? $clog2(DIM) : 1;
    localparam int unsigned OFF_W = $clog2(MW);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DIM - 1);

    state_t state;
    state_t state_next;

    logic [MW-1:0]     a_reg;
    logic [MW-1:0]     b_reg;
    logic [MW-1:0]     res;
    logic [MW-1:0]     res_next;
    logic [ELEM_W-1:0] acc;
    logic [ELEM_W-1:0] mac_a;
    logic [ELEM_W-1:0] mac_b;
    logic [ELEM_W-1:0] mac_out;
    logic [CNT_W-1:0]  row;
    logic [CNT_W-1:0]  col;
    logic [CNT_W-1:0]  k;
    logic [OFF_W-1:0]  a_off;
    logic [OFF_W-1:0]  b_off;
    logic [OFF_W-1:0]  r_off;
    logic              load;
    logic              elem_last;
    logic              op_last;

    mac16 #(
        .W(ELEM_W)
    ) u_mac (
        .a      (mac_a),
        .b      (mac_b),
        .acc_in (acc),
        .acc_out(mac_out)
    );

    // Operand selection A[row][k], B[k][col] and the result slot (row,col).
    always_comb begin
        a_off     = OFF_W'(elem_off(32'(row), 32'(k),   ELEM_W, DIM));
        b_off     = OFF_W'(elem_off(32'(k),   32'(col), ELEM_W, DIM));
        r_off     = OFF_W'(elem_off(32'(row), 32'(col), ELEM_W, DIM));
        mac_a     = a_reg[a_off +: ELEM_W];
        mac_b     = b_reg[b_off +: ELEM_W];
        elem_last = (k == CNT_LAST);
        op_last   = elem_last && (row == CNT_LAST) && (col == CNT_LAST);
    end

    // Result image with the finishing element merged in, so the completion
    // edge can publish all elements including the one written that cycle.
    always_comb begin
        res_next = res;
        if (elem_last) begin
            res_next[r_off +: ELEM_W] = mac_out;
        end
    end

    // Next-state logic and operand load request.
    always_comb begin
        state_next = state;
        load       = 1'b0;
        unique case (state)
            IDLE: begin
                if (start) begin
                    load       = 1'b1;
                    state_next = CALC;
                end
            end
            CALC: begin
                if (op_last) begin
                    state_next = DONE;
                end
            end
            DONE: begin
                // The edge leaving DONE doubles as the first idle sample, giving
                // one operation per 65 cycles when start is held high.
                if (start) begin
                    load       = 1'b1;
                    state_next = CALC;
                end else begin
                    state_next = IDLE;
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    // State register.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Registered status flags decoded from the upcoming state.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            busy <= 1'b0;
            done <= 1'b0;
        end else begin
            busy <= (state_next == CALC);
            done <= (state_next == DONE);
        end
    end

    // Operand capture, counters, accumulator and result registers.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            a_reg <= '0;
            b_reg <= '0;
            res   <= '0;
            acc   <= '0;
            row   <= '0;
            col   <= '0;
            k     <= '0;
            m_out <= '0;
        end else if (load) begin
            a_reg <= m1;
            b_reg <= m2;
            res   <= '0;
            acc   <= '0;
            row   <= '0;
            col   <= '0;
            k     <= '0;
        end else if (state == CALC) begin
            res <= res_next;
            if (elem_last) begin
                acc <= '0;
                k   <= '0;
                if (col == CNT_LAST) begin
                    col <= '0;
                    row <= row + 1'b1;
                end else begin
                    col <= col + 1'b1;
                end
            end else begin
                acc <= mac_out;
                k   <= k + 1'b1;
            end
            if (op_last) begin
                m_out <= res_next;
            end
        end
    end

endmodule
